// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control-bundle register with multi-cycle bubble insertion,
// branch/jump flush, debug freeze and a saturating bubble counter.
//
// Ports:
//   i_clk           rising-edge clock
//   i_reset         asynchronous active-low reset
//   i_enable        pipeline step enable; 0 freezes every register
//   is_ctrl         decoded control bundle
//   is_hazard       bubble request from the hazard detector
//   is_bubble_len   bubbles requested with is_hazard (0 means 1)
//   is_flush        branch/jump squash request
//   os_ctrl         registered control bundle to EX
//   os_bubble       1 when os_ctrl holds an inserted NOP
//   os_stall        combinational hold for PC and IF/ID
//   os_bubble_count saturating count of inserted NOPs
module id_ex_ctrl_stage #(
    parameter int unsigned       CTRL_W    = 16,
    parameter int unsigned       CNT_W     = 2,
    parameter logic [CTRL_W-1:0] NOP_VALUE = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [CTRL_W-1:0] is_ctrl,
    input  logic              is_hazard,
    input  logic [CNT_W-1:0]  is_bubble_len,
    input  logic              is_flush,
    output logic [CTRL_W-1:0] os_ctrl,
    output logic              os_bubble,
    output logic              os_stall,
    output logic [15:0]       os_bubble_count
);

    typedef enum logic {
        RUN,
        BUBBLE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              bubble_q, bubble_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]  leff;
    logic              load_nop;

    assign leff = (is_bubble_len == '0) ? ONE : is_bubble_len;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        ctrl_d   = ctrl_q;
        bubble_d = bubble_q;
        cnt_d    = cnt_q;
        load_nop = 1'b0;
        if (i_enable) begin
            unique case (state_q)
                RUN: begin
                    if (is_flush) begin
                        load_nop = 1'b1;
                    end else if (is_hazard) begin
                        load_nop = 1'b1;
                        rem_d    = leff - ONE;
                        if (leff > ONE) begin
                            state_d = BUBBLE;
                        end
                    end else begin
                        ctrl_d   = is_ctrl;
                        bubble_d = 1'b0;
                    end
                end
                BUBBLE: begin
                    load_nop = 1'b1;
                    if (is_flush) begin
                        rem_d   = '0;
                        state_d = RUN;
                    end else begin
                        rem_d = rem_q - ONE;
                        // rem_q==0 cannot occur here; treat it as last
                        if (rem_q <= ONE) begin
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
            if (load_nop) begin
                ctrl_d   = NOP_VALUE;
                bubble_d = 1'b1;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= RUN;
            rem_q    <= '0;
            ctrl_q   <= NOP_VALUE;
            bubble_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            ctrl_q   <= ctrl_d;
            bubble_q <= bubble_d;
            cnt_q    <= cnt_d;
        end
    end

    assign os_stall = !i_enable
                    || (state_q == BUBBLE && !is_flush)
                    || (state_q == RUN && is_hazard && !is_flush);

    assign os_ctrl         = ctrl_q;
    assign os_bubble       = bubble_q;
    assign os_bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage: expected outputs are queued
// as stimulus is driven and compared after each clock edge.
module tb_id_ex_ctrl_stage;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_enable = 1'b1;
    logic [15:0] is_ctrl = '0;
    logic        is_hazard = 1'b0;
    logic [1:0]  is_bubble_len = '0;
    logic        is_flush = 1'b0;
    logic [15:0] os_ctrl;
    logic        os_bubble;
    logic        os_stall;
    logic [15:0] os_bubble_count;

    id_ex_ctrl_stage #(
        .CTRL_W(16),
        .CNT_W(2),
        .NOP_VALUE(16'h0000)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .is_ctrl(is_ctrl),
        .is_hazard(is_hazard),
        .is_bubble_len(is_bubble_len),
        .is_flush(is_flush),
        .os_ctrl(os_ctrl),
        .os_bubble(os_bubble),
        .os_stall(os_stall),
        .os_bubble_count(os_bubble_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] ctrl;
        logic        bub;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [15:0] c;
        logic        h;
        logic [1:0]  len;
        logic        f;
        logic        en;
        logic        st;
        logic [15:0] ec;
        logic        eb;
        logic        hold;
    } row_t;

    exp_t        sb[$];
    exp_t        last;
    logic [15:0] exp_cnt = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic row_t R(input logic [15:0] c, input logic h,
                               input logic [1:0] len, input logic f,
                               input logic en, input logic st,
                               input logic [15:0] ec, input logic eb,
                               input logic hold);
        row_t r;
        r.c = c; r.h = h; r.len = len; r.f = f; r.en = en;
        r.st = st; r.ec = ec; r.eb = eb; r.hold = hold;
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drive(input row_t r);
        is_ctrl       = r.c;
        is_hazard     = r.h;
        is_bubble_len = r.len;
        is_flush      = r.f;
        i_enable      = r.en;
    endtask

    task automatic push(input logic [15:0] c, input logic b);
        exp_t e;
        if (b && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.ctrl = c; e.bub = b; e.cnt = exp_cnt;
        sb.push_back(e);
        last = e;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(R(16'h0000, 0, 0, 1, 1, 0, 0, 0, 0));
        tick();
        drive(R(16'h1234, 0, 0, 0, 1, 0, 0, 0, 0));
        tick();
        #2 i_reset = 1'b0;
        #1;
        n_tests++;
        if (os_ctrl !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %h want 0000", os_ctrl);
        end
        n_tests++;
        if (os_bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bubble got %b want 0", os_bubble);
        end
        n_tests++;
        if (os_bubble_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_count got %h want 0000", os_bubble_count);
        end
        @(posedge i_clk);
        #1;
        n_tests++;
        if (os_ctrl !== 16'h0000 || os_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold ctrl=%h stall=%b want 0000/0",
                     os_ctrl, os_stall);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        exp_cnt = '0;
        sb.delete();
        push(16'h1234, 1'b0);
        tick();
        e = sb.pop_front();
        n_tests++;
        if (os_ctrl !== e.ctrl || os_bubble !== e.bub || os_bubble_count !== e.cnt) begin
            n_fail++;
            $display("FAIL reset_release ctrl=%h/%h bub=%b/%b cnt=%h/%h",
                     os_ctrl, e.ctrl, os_bubble, e.bub, os_bubble_count, e.cnt);
        end
    endtask

    task automatic run_rows(input string name, input row_t rows[$]);
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (os_stall !== rows[i].st) begin
                n_fail++;
                $display("FAIL %s_stall[%0d] got %b want %b",
                         name, i, os_stall, rows[i].st);
            end
            if (rows[i].hold) sb.push_back(last);
            else push(rows[i].ec, rows[i].eb);
            tick();
            e = sb.pop_front();
            n_tests++;
            if (os_ctrl !== e.ctrl || os_bubble !== e.bub || os_bubble_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s_out[%0d] ctrl=%h/%h bub=%b/%b cnt=%h/%h",
                         name, i, os_ctrl, e.ctrl, os_bubble, e.bub,
                         os_bubble_count, e.cnt);
            end
        end
    endtask

    task automatic test_single();
        row_t r[$];
        r.push_back(R(16'h00A5, 1, 0, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h00A5, 0, 0, 0, 1, 0, 16'h00A5, 0, 0));
        run_rows("single", r);
    endtask

    task automatic test_multi();
        row_t r[$];
        r.push_back(R(16'h0B0B, 1, 3, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0B0B, 1, 3, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0B0B, 0, 0, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0B0B, 0, 0, 0, 1, 0, 16'h0B0B, 0, 0));
        run_rows("multi", r);
    endtask

    task automatic test_flush();
        row_t r[$];
        r.push_back(R(16'h00C1, 1, 3, 1, 1, 0, 16'h0000, 1, 0));
        r.push_back(R(16'h00C1, 0, 0, 0, 1, 0, 16'h00C1, 0, 0));
        r.push_back(R(16'h00C2, 1, 3, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h00C2, 0, 0, 1, 1, 0, 16'h0000, 1, 0));
        r.push_back(R(16'h00C2, 0, 0, 0, 1, 0, 16'h00C2, 0, 0));
        run_rows("flush", r);
    endtask

    task automatic test_freeze();
        row_t r[$];
        r.push_back(R(16'h00D4, 1, 2, 0, 1, 1, 16'h0000, 1, 0));
        for (int k = 0; k < 5; k++)
            r.push_back(R(16'h5555, 1, 3, 0, 0, 1, 16'h0000, 0, 1));
        r.push_back(R(16'h00D4, 0, 0, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h00D4, 0, 0, 0, 1, 0, 16'h00D4, 0, 0));
        r.push_back(R(16'h00EE, 0, 0, 0, 0, 1, 16'h0000, 0, 1));
        r.push_back(R(16'h00EE, 1, 3, 1, 0, 1, 16'h0000, 0, 1));
        r.push_back(R(16'h00EE, 0, 0, 0, 1, 0, 16'h00EE, 0, 0));
        run_rows("freeze", r);
    endtask

    task automatic test_back_to_back();
        row_t r[$];
        r.push_back(R(16'h0011, 1, 1, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0022, 1, 1, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0033, 0, 0, 0, 1, 0, 16'h0033, 0, 0));
        r.push_back(R(16'h0044, 1, 2, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0044, 1, 2, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0044, 1, 2, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0055, 0, 0, 0, 1, 1, 16'h0000, 1, 0));
        r.push_back(R(16'h0055, 0, 0, 0, 1, 0, 16'h0055, 0, 0));
        run_rows("b2b", r);
    endtask

    task automatic test_reset_mid_bubble();
        row_t r[$];
        exp_t e;
        r.push_back(R(16'h0077, 1, 3, 0, 1, 1, 16'h0000, 1, 0));
        run_rows("midrst_pre", r);
        is_hazard = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        n_tests++;
        if (os_bubble !== 1'b0 || os_bubble_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_regs bub=%b cnt=%h want 0/0000",
                     os_bubble, os_bubble_count);
        end
        n_tests++;
        if (os_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stall got %b want 0", os_stall);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        exp_cnt = '0;
        sb.delete();
        #1;
        n_tests++;
        if (os_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release_stall got %b want 0", os_stall);
        end
        push(16'h0077, 1'b0);
        tick();
        e = sb.pop_front();
        n_tests++;
        if (os_ctrl !== e.ctrl || os_bubble !== e.bub || os_bubble_count !== e.cnt) begin
            n_fail++;
            $display("FAIL midrst_out ctrl=%h/%h bub=%b/%b cnt=%h/%h",
                     os_ctrl, e.ctrl, os_bubble, e.bub, os_bubble_count, e.cnt);
        end
    endtask

    task automatic test_saturation();
        row_t r[$];
        drive(R(16'h0000, 0, 0, 1, 1, 0, 16'h0000, 1, 0));
        repeat (65534) tick();
        n_tests++;
        if (os_bubble_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_preload got %h want FFFE", os_bubble_count);
        end
        exp_cnt = 16'hFFFE;
        for (int k = 0; k < 3; k++)
            r.push_back(R(16'h0000, 0, 0, 1, 1, 0, 16'h0000, 1, 0));
        r.push_back(R(16'h0099, 0, 0, 0, 1, 0, 16'h0099, 0, 0));
        run_rows("sat", r);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        test_reset();
        test_single();
        test_multi();
        test_flush();
        test_freeze();
        test_back_to_back();
        test_reset_mid_bubble();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_stage.md
# id_ex_ctrl_stage

Parametrised ID/EX control-bundle pipeline register with multi-cycle bubble insertion, flush and debug freeze. It sits between the decoder/control unit and the EX stage. It replaces the combinational zero-select on the control path with a registered stage that does three things:
- inserts 1..N NOP bubbles on a hazard request while holding PC and IF/ID;
- squashes on branch/jump flush;
- keeps a saturating count of inserted bubbles for the debug unit.

## Interface
Parameters:
- CTRL_W, 16, width of the packed control bundle (RegDst, MemRead, MemWrite, MemtoReg, ALUop, ALUsrc, RegWrite, shmat, load_store_type).
- CNT_W, 2, width of the bubble-length request; maximum bubbles = 2^CNT_W - 1.
- NOP_VALUE, 0, CTRL_W-bit bundle loaded as a bubble.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_enable  in  1  pipeline step enable from the debug unit; 0 freezes the stage.
- is_ctrl  in  CTRL_W  control bundle from the decoder.
- is_hazard  in  1  bubble request from the hazard detector.
- is_bubble_len  in  CNT_W  number of bubbles requested with is_hazard; 0 is treated as 1.
- is_flush  in  1  branch/jump squash request.
- os_ctrl  out  CTRL_W  registered bundle to EX.
- os_bubble  out  1  registered; 1 when os_ctrl holds an inserted NOP.
- os_stall  out  1  combinational; hold PC and IF/ID this cycle.
- os_bubble_count  out  16  saturating count of inserted NOPs.

## Operation
- FSM states: RUN, BUBBLE.
- rem is a CNT_W-bit register of remaining bubbles.
- Leff = (is_bubble_len == 0) ? 1 : is_bubble_len.
- Priority on every enabled edge: flush > hazard/bubble > normal.

RUN state, rising edge with i_enable=1:
- is_flush=1: os_ctrl<=NOP_VALUE, os_bubble<=1, stay RUN. A simultaneous is_hazard is ignored.
- else is_hazard=1: os_ctrl<=NOP_VALUE, os_bubble<=1, rem<=Leff-1. Go to BUBBLE if Leff>1, else stay RUN.
- else: os_ctrl<=is_ctrl, os_bubble<=0.

BUBBLE state, rising edge with i_enable=1:
- is_flush=1: os_ctrl<=NOP_VALUE, os_bubble<=1, rem<=0, go RUN (the hazard is aborted).
- else: os_ctrl<=NOP_VALUE, os_bubble<=1, rem<=rem-1. Go RUN when rem==1.
- is_hazard is ignored in BUBBLE; it is not queued.

Stall and counter:
- os_stall = ~i_enable | (state==BUBBLE & ~is_flush) | (state==RUN & is_hazard & ~is_flush).
- os_bubble_count increments by 1 on every enabled edge that loads NOP_VALUE (hazard or flush) and saturates at 16'hFFFF.

Freeze and reset:
- i_enable=0: all registers (os_ctrl, os_bubble, state, rem, os_bubble_count) hold their values.
- Reset (i_reset=0), immediate and independent of i_clk: os_ctrl=NOP_VALUE, os_bubble=0, state=RUN, rem=0, os_bubble_count=0.
- os_stall during reset follows its equation with state=RUN.

## Timing
- Latency: is_ctrl appears on os_ctrl one enabled edge after sampling.
- os_stall is combinational from is_hazard, is_flush and i_enable, and is valid in the same cycle.
- A hazard of length L gives exactly L consecutive enabled edges loading NOP. os_stall is high for exactly those L cycles: the request cycle plus L-1 BUBBLE cycles.
- The instruction held in IF/ID is sampled from is_ctrl on the first enabled edge after os_stall drops.
- Reset deassertion mid-bubble returns to RUN with no residual bubbles.
- No combinational path exists from is_ctrl to any output.

## Test plan
- Reset: hold i_reset=0 mid-cycle with is_ctrl=16'h1234 -> os_ctrl=16'h0000, os_bubble=0, os_bubble_count=0 immediately. After release, the next edge gives os_ctrl=16'h1234.
- Single bubble: is_hazard=1 with is_bubble_len=0 for one cycle, is_ctrl=16'h00A5 -> os_stall=1 for one cycle, one NOP with os_bubble=1. The next edge gives os_ctrl=16'h00A5 and os_bubble_count=1.
- Multi bubble: is_bubble_len=3 pulse -> three consecutive NOP edges and os_stall high for three cycles. A second is_hazard in cycle 2 is ignored; os_bubble_count=3.
- Flush priority: is_hazard=1 and is_flush=1 in RUN -> one NOP, os_stall=0, state stays RUN. Flush in BUBBLE with rem=2 -> NOP loaded, state RUN, stall drops the same cycle.
- Freeze: i_enable=0 for 5 cycles during BUBBLE with rem=1 -> os_ctrl, rem, os_bubble_count unchanged and os_stall=1. After re-enable, exactly one more NOP, then RUN.
- Saturation: preload the counter to 16'hFFFE via 2 bubbles beyond 65534 -> os_bubble_count stays at 16'hFFFF.
